xbar_rsp_buffer: RTL
====================

// Module: xbar_rsp_buffer
// PURPOSE
//  Response-return half of the xbar: accepts per-bank responses and returns them to the
//  originating upstream channel in request order. Per channel, an ENTRY_NUM-deep reorder
//  buffer is indexed by the request entry id the request side allocated (its w_ptr).
//  Drains strictly in entry order from a read pointer; exports that pointer as a credit.
// PARAMETERS
//  CH_NUM     3    upstream channels
//  BANK_NUM   4    cache banks returning responses
//  ENTRY_NUM  8    ROB entries per channel; equals the request-side entries per channel
//  ENT_W      3    $clog2(ENTRY_NUM)
// PORTS
//  clk                  in   1                     clock
//  rst                  in   1                     async reset, active-high
//  d_bank_rsp_valid     in   BANK_NUM              bank response valid
//  d_bank_rsp_ready     out  BANK_NUM              bank response ready
//  d_bank_rsp           in   BANK_NUM x rsp_t      {ch_id[1:0], entry_id[ENT_W-1:0], data[127:0]}
//  u_ch_rsp_valid       out  CH_NUM                channel response valid
//  u_ch_rsp_ready       in   CH_NUM                channel response ready
//  u_ch_rsp             out  CH_NUM x rsp_t        response presented to the channel
//  ch_r_ptr             out  CH_NUM x ENT_W        next entry to drain (freed-entry credit)
//  ch_rsp_cnt           out  CH_NUM x (ENT_W+1)    filled-entry count per channel
//  err_dup_wr           out  1                     sticky protocol-error flag
// BEHAVIOUR
//  - Reset: all entry valid bits 0; r_ptr 0; cnt 0; err_dup_wr 0; u_ch_rsp_valid 0; u_ch_rsp '0.
//  - d_bank_rsp_ready = ~rst (no backpressure). Every entry owns a request-side allocation.
//  - Write: bank b handshake -> entry[ch_id][entry_id] <= rsp; valid set at the next edge.
//    Banks may write different entries of one channel in the same cycle.
//    Visibility: a write at edge N is drainable at the earliest after edge N.
//  - Dup/illegal write: target entry already valid, ch_id >= CH_NUM, or two banks targeting
//    the same {ch,entry} in one cycle -> err_dup_wr set (sticky until rst).
//    Same-cycle collision: lowest bank index wins. An already-valid entry is not overwritten.
//  - Drain: u_ch_rsp_valid[c] = vld[c][r_ptr[c]]; u_ch_rsp[c] = entry[c][r_ptr[c]].
//    Output is a mux of registers, with no combinational path from the bank inputs.
//    Handshake clears vld[c][r_ptr[c]]; r_ptr increments and wraps ENTRY_NUM-1 -> 0.
//    Valid stays asserted and data stays stable while ready is low.
//  - Head-of-line: out-of-order arrivals wait until lower entries fill.
//    No bypass when the head entry is empty.
//  - Simultaneous drain of entry k and write of entry j (j!=k) in one channel: both take
//    effect. cnt changes by +writes-1. Write to the draining entry -> err_dup_wr, write dropped.
//  - Wrap: r_ptr=7 drained -> r_ptr=0. Full: cnt==ENTRY_NUM, all valid, no special-casing.
//  - Reset asserted mid-operation clears all state immediately. Buffered responses are lost.
//    The request side is reset by the same rst.
//  - No arbitration state between channels. Each channel is independent.
// STRUCTURE
//  - mpc_types: typedef channel_rsp_t {ch_id, entry_id, data}. Constants XBAR_CH_NUM,
//    XBAR_BANK_NUM, XBAR_ENTRY_NUM.
//  - Sub-module xbar_sub_rsp_rob: one per channel, generated CH_NUM times.
//    It holds the entries, valid bits, r_ptr, cnt and its local dup error.
//  - Top: decode each bank's {ch_id,entry_id} into per-channel write enables with a
//    priority-by-bank-index write mux. OR the per-channel dup errors into the sticky flag.
// TESTING
//  1. In-order: bank0 returns ch0 entries 0,1,2 in consecutive cycles, ready=1
//     -> u_ch_rsp[0] data matches in order 0,1,2. Each appears 1 cycle after its write.
//     Final r_ptr=3, cnt=0.
//  2. Out-of-order: ch1 entries 2,1,0 arrive via banks 3,2,1.
//     -> no valid until entry 0 is written, then 0,1,2 drain back-to-back. Final r_ptr=3.
//  3. Multi-bank same cycle: banks 0-3 write ch2 entries 4-7 together with r_ptr=4
//     -> cnt=4 next cycle. Drained 4,5,6,7; r_ptr wraps to 0.
//  4. Backpressure + full: fill all 8 ch0 entries with ready=0
//     -> cnt=8, valid held, data stable. Release ready -> 8 beats; r_ptr back to 0, cnt 0.
//  5. Error: banks 1 and 2 both write ch0 entry 3 in the same cycle
//     -> err_dup_wr=1 next cycle, bank1 data stored. Rewrite of valid entry 3 -> data unchanged.
//  6. Reset mid-op: assert rst with 5 entries buffered
//     -> valid=0, cnt=0, r_ptr=0, err=0, ready=0 during rst. Normal operation resumes after.

Source files
------------

// File: rtl/xbar_rsp_buffer_pkg.sv
// Shared types and constants for the xbar response-return path.
// The response word is {ch_id, entry_id, data}, with ch_id in the most significant bits.
package xbar_rsp_buffer_pkg;

  localparam int XBAR_CH_NUM    = 3;
  localparam int XBAR_BANK_NUM  = 4;
  localparam int XBAR_ENTRY_NUM = 8;
  localparam int XBAR_ENT_W     = 3;
  localparam int XBAR_CH_W      = 2;
  localparam int XBAR_DATA_W    = 128;

  typedef struct packed {
    logic [XBAR_CH_W-1:0]   ch_id;
    logic [XBAR_ENT_W-1:0]  entry_id;
    logic [XBAR_DATA_W-1:0] data;
  } channel_rsp_t;

  localparam int XBAR_RSP_W = $bits(channel_rsp_t);

  // A channel id is legal only if it names an existing upstream channel.
  function automatic logic ch_id_legal(input logic [XBAR_CH_W-1:0] ch_id);
    return (ch_id < XBAR_CH_W'(XBAR_CH_NUM));
  endfunction

endpackage

// File: rtl/xbar_sub_rsp_rob.sv
// Per-channel reorder buffer: entries indexed by request entry id, drained in order
// from r_ptr. The output is a plain mux of registers.
module xbar_sub_rsp_rob
  import xbar_rsp_buffer_pkg::*;
#(
  parameter int ENTRY_NUM = XBAR_ENTRY_NUM,
  parameter int ENT_W     = XBAR_ENT_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [ENTRY_NUM-1:0]            wr_en,
  input  logic [ENTRY_NUM-1:0]            wr_multi,
  input  logic [ENTRY_NUM*XBAR_RSP_W-1:0] wr_data,
  input  logic                            rsp_ready,
  output logic                            rsp_valid,
  output logic [XBAR_RSP_W-1:0]           rsp,
  output logic [ENT_W-1:0]                r_ptr,
  output logic [ENT_W:0]                  cnt,
  output logic                            dup_err
);

  logic [XBAR_RSP_W-1:0] ent_r [ENTRY_NUM];
  logic [ENTRY_NUM-1:0]  vld_r;
  logic [ENT_W-1:0]      r_ptr_r;
  logic [ENT_W:0]        cnt_r;

  logic [ENTRY_NUM-1:0]  wr_ok_s;
  logic [ENTRY_NUM-1:0]  drain_clr_s;
  logic                  drain_s;
  logic [ENT_W:0]        n_wr_s;

  // Accept writes only into empty entries; a write aimed at a valid entry
  // (including the one draining this cycle) is dropped and flagged.
  always_comb begin
    wr_ok_s     = wr_en & ~vld_r;
    drain_s     = vld_r[r_ptr_r] & rsp_ready;
    drain_clr_s = '0;
    drain_clr_s[r_ptr_r] = drain_s;
    n_wr_s      = '0;
    for (int e = 0; e < ENTRY_NUM; e++) begin
      n_wr_s = n_wr_s + {{ENT_W{1'b0}}, wr_ok_s[e]};
    end
    dup_err     = (|(wr_en & vld_r)) | (|wr_multi);
  end

  assign rsp_valid = vld_r[r_ptr_r];
  assign rsp       = ent_r[r_ptr_r];
  assign r_ptr     = r_ptr_r;
  assign cnt       = cnt_r;

  // Entry storage, valid bits, drain pointer and fill count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < ENTRY_NUM; e++) begin
        ent_r[e] <= '0;
      end
      vld_r   <= '0;
      r_ptr_r <= '0;
      cnt_r   <= '0;
    end else begin
      for (int e = 0; e < ENTRY_NUM; e++) begin
        if (wr_ok_s[e]) begin
          ent_r[e] <= wr_data[e*XBAR_RSP_W +: XBAR_RSP_W];
        end
      end
      vld_r <= (vld_r & ~drain_clr_s) | wr_ok_s;
      if (drain_s) begin
        r_ptr_r <= (r_ptr_r == ENT_W'(ENTRY_NUM-1)) ? '0 : r_ptr_r + ENT_W'(1);
      end
      cnt_r <= cnt_r + n_wr_s - {{ENT_W{1'b0}}, drain_s};
    end
  end

endmodule

// File: rtl/xbar_rsp_buffer.sv
// Response-return half of the xbar: routes bank responses into per-channel reorder
// buffers and returns them upstream in request order.
module xbar_rsp_buffer
  import xbar_rsp_buffer_pkg::*;
#(
  parameter int CH_NUM    = XBAR_CH_NUM,
  parameter int BANK_NUM  = XBAR_BANK_NUM,
  parameter int ENTRY_NUM = XBAR_ENTRY_NUM,
  parameter int ENT_W     = XBAR_ENT_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [BANK_NUM-1:0]            d_bank_rsp_valid,
  output logic [BANK_NUM-1:0]            d_bank_rsp_ready,
  input  logic [BANK_NUM*XBAR_RSP_W-1:0] d_bank_rsp,
  output logic [CH_NUM-1:0]              u_ch_rsp_valid,
  input  logic [CH_NUM-1:0]              u_ch_rsp_ready,
  output logic [CH_NUM*XBAR_RSP_W-1:0]   u_ch_rsp,
  output logic [CH_NUM*ENT_W-1:0]        ch_r_ptr,
  output logic [CH_NUM*(ENT_W+1)-1:0]    ch_rsp_cnt,
  output logic                           err_dup_wr
);

  channel_rsp_t        bank_rsp_s [BANK_NUM];
  logic [BANK_NUM-1:0] bank_fire_s;
  logic                bad_ch_s;
  logic [CH_NUM-1:0]   ch_dup_s;
  logic                err_dup_wr_r;

  assign d_bank_rsp_ready = ~{BANK_NUM{rst}};

  // Unpack bank responses and flag writes addressed to a non-existent channel.
  always_comb begin
    bank_fire_s = d_bank_rsp_valid & ~{BANK_NUM{rst}};
    bad_ch_s    = 1'b0;
    for (int b = 0; b < BANK_NUM; b++) begin
      bank_rsp_s[b] = channel_rsp_t'(d_bank_rsp[b*XBAR_RSP_W +: XBAR_RSP_W]);
      bad_ch_s      = bad_ch_s | (bank_fire_s[b] & ~ch_id_legal(bank_rsp_s[b].ch_id));
    end
  end

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    logic [BANK_NUM-1:0]            hit_s [ENTRY_NUM];
    logic [ENTRY_NUM-1:0]           wr_en_s;
    logic [ENTRY_NUM-1:0]           wr_multi_s;
    logic [ENTRY_NUM*XBAR_RSP_W-1:0] wr_data_s;

    // Per-entry write decode; the lowest-numbered bank wins a same-entry collision.
    always_comb begin
      wr_en_s    = '0;
      wr_multi_s = '0;
      wr_data_s  = '0;
      for (int e = 0; e < ENTRY_NUM; e++) begin
        for (int b = 0; b < BANK_NUM; b++) begin
          hit_s[e][b] = bank_fire_s[b]
                      & (bank_rsp_s[b].ch_id == XBAR_CH_W'(c))
                      & (bank_rsp_s[b].entry_id == ENT_W'(e));
        end
        wr_en_s[e]    = |hit_s[e];
        wr_multi_s[e] = |(hit_s[e] & (hit_s[e] - BANK_NUM'(1)));
        for (int b = BANK_NUM - 1; b >= 0; b--) begin
          wr_data_s[e*XBAR_RSP_W +: XBAR_RSP_W] = hit_s[e][b] ? bank_rsp_s[b]
                                                : wr_data_s[e*XBAR_RSP_W +: XBAR_RSP_W];
        end
      end
    end

    xbar_sub_rsp_rob #(
      .ENTRY_NUM (ENTRY_NUM),
      .ENT_W     (ENT_W)
    ) u_rob (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en_s),
      .wr_multi  (wr_multi_s),
      .wr_data   (wr_data_s),
      .rsp_ready (u_ch_rsp_ready[c]),
      .rsp_valid (u_ch_rsp_valid[c]),
      .rsp       (u_ch_rsp[c*XBAR_RSP_W +: XBAR_RSP_W]),
      .r_ptr     (ch_r_ptr[c*ENT_W +: ENT_W]),
      .cnt       (ch_rsp_cnt[c*(ENT_W+1) +: (ENT_W+1)]),
      .dup_err   (ch_dup_s[c])
    );
  end

  // Sticky protocol-error flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_dup_wr_r <= 1'b0;
    end else if (bad_ch_s | (|ch_dup_s)) begin
      err_dup_wr_r <= 1'b1;
    end
  end

  assign err_dup_wr = err_dup_wr_r;

endmodule
